// File: rtl/adv_instr_sel_pipe.sv
// adv_instr_sel_pipe: pipelined MIPS advanced-instruction selector.
// Decodes SRA/SRAV/LUI/ORI/BNE into a one-hot class, carries it through a
// valid/ready pipeline of STAGES registers, and keeps per-class saturating
// event counters of completed output transfers.
`timescale 1ns/1ps

module adv_instr_sel_pipe #(
    parameter int unsigned STAGES   = 2,
    parameter int unsigned CNT_W    = 16,
    parameter logic [4:0]  ADV_MASK = 5'b11111
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      instr_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             flush_i,
    output logic [31:0]      instr_o,
    output logic [4:0]       class_o,
    output logic             select_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    input  logic [2:0]       cnt_sel_i,
    input  logic             cnt_clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [5:0]        op;
    logic [5:0]        funct;
    logic [4:0]        dec_cls;

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] rdy;
    logic [31:0]       ins_q [STAGES];
    logic [4:0]        cls_q [STAGES];

    logic [CNT_W-1:0]  cnt_q [5];
    logic              out_xfer;

    assign op    = instr_i[31:26];
    assign funct = instr_i[5:0];

    // Class decode of the incoming word; funct only matters for op 000000.
    always_comb begin
        dec_cls = '0;
        case (op)
            6'b000000: begin
                if (funct == 6'b000011) begin
                    dec_cls[0] = 1'b1;
                end else if (funct == 6'b000111) begin
                    dec_cls[1] = 1'b1;
                end
            end
            6'b001111: dec_cls[2] = 1'b1;
            6'b001101: dec_cls[3] = 1'b1;
            6'b000101: dec_cls[4] = 1'b1;
            default:   dec_cls    = '0;
        endcase
    end

    // Stage k can take new content when any stage from k to the output is
    // empty or the output is draining; computed flat to avoid a comb chain.
    always_comb begin
        rdy = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            rdy[k] = out_ready_i;
            for (int unsigned j = k; j < STAGES; j++) begin
                if (!vld[j]) begin
                    rdy[k] = 1'b1;
                end
            end
        end
    end

    assign in_ready_o  = rdy[0];
    assign out_valid_o = vld[STAGES-1];
    assign instr_o     = ins_q[STAGES-1];
    assign class_o     = cls_q[STAGES-1];
    assign select_o    = |(class_o & ADV_MASK);
    assign out_xfer    = out_valid_o & out_ready_i;

    // Pipeline registers: each stage moves forward when ready; flush clears valids only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                ins_q[k] <= '0;
                cls_q[k] <= '0;
            end
        end else begin
            if (rdy[0]) begin
                vld[0] <= in_valid_i;
                if (in_valid_i) begin
                    ins_q[0] <= instr_i;
                    cls_q[0] <= dec_cls;
                end
            end
            for (int unsigned k = 1; k < STAGES; k++) begin
                if (rdy[k]) begin
                    vld[k] <= vld[k-1];
                    if (vld[k-1]) begin
                        ins_q[k] <= ins_q[k-1];
                        cls_q[k] <= cls_q[k-1];
                    end
                end
            end
            if (flush_i) begin
                vld <= '0;
            end
        end
    end

    // Per-class event counters: count completed output transfers, saturate, clear wins.
    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < 5; i++) begin
            if (rst_i || cnt_clr_i) begin
                cnt_q[i] <= '0;
            end else if (out_xfer && class_o[i] && (cnt_q[i] != '1)) begin
                cnt_q[i] <= cnt_q[i] + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Counter read mux; indices beyond the five classes read zero.
    always_comb begin
        cnt_o = '0;
        if (cnt_sel_i < 3'd5) begin
            cnt_o = cnt_q[cnt_sel_i];
        end
    end

endmodule

// File: tb/tb_adv_instr_sel_pipe.sv
// tb_adv_instr_sel_pipe: table-driven scoreboard bench for adv_instr_sel_pipe.
// Three instances share stimulus: default, ADV_MASK=00011, and CNT_W=3.
`timescale 1ns/1ps

module tb_adv_instr_sel_pipe;

    localparam int unsigned STAGES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        in_valid;
    logic        flush;
    logic        out_ready;
    logic [2:0]  cnt_sel;
    logic        cnt_clr;

    logic        rdy0, rdy1, rdy2;
    logic        ov0, ov1, ov2;
    logic [31:0] io0, io1, io2;
    logic [4:0]  cls0, cls1, cls2;
    logic        sel0, sel1, sel2;
    logic [15:0] cnt0, cnt1;
    logic [2:0]  cnt2;

    always #10 clk = ~clk;

    adv_instr_sel_pipe #(.STAGES(STAGES), .CNT_W(16), .ADV_MASK(5'b11111)) dut0 (
        .clk_i(clk), .rst_i(rst), .instr_i(instr), .in_valid_i(in_valid),
        .in_ready_o(rdy0), .flush_i(flush), .instr_o(io0), .class_o(cls0),
        .select_o(sel0), .out_valid_o(ov0), .out_ready_i(out_ready),
        .cnt_sel_i(cnt_sel), .cnt_clr_i(cnt_clr), .cnt_o(cnt0)
    );

    adv_instr_sel_pipe #(.STAGES(STAGES), .CNT_W(16), .ADV_MASK(5'b00011)) dut1 (
        .clk_i(clk), .rst_i(rst), .instr_i(instr), .in_valid_i(in_valid),
        .in_ready_o(rdy1), .flush_i(flush), .instr_o(io1), .class_o(cls1),
        .select_o(sel1), .out_valid_o(ov1), .out_ready_i(out_ready),
        .cnt_sel_i(cnt_sel), .cnt_clr_i(cnt_clr), .cnt_o(cnt1)
    );

    adv_instr_sel_pipe #(.STAGES(STAGES), .CNT_W(3), .ADV_MASK(5'b11111)) dut2 (
        .clk_i(clk), .rst_i(rst), .instr_i(instr), .in_valid_i(in_valid),
        .in_ready_o(rdy2), .flush_i(flush), .instr_o(io2), .class_o(cls2),
        .select_o(sel2), .out_valid_o(ov2), .out_ready_i(out_ready),
        .cnt_sel_i(cnt_sel), .cnt_clr_i(cnt_clr), .cnt_o(cnt2)
    );

    typedef struct {
        logic [31:0] ins;
        logic [4:0]  cls;
        logic        sel;
    } vec_t;

    typedef struct {
        logic [31:0] ins;
        logic [4:0]  cls;
        logic        sel;
        int unsigned acc;
    } exp_t;

    vec_t        tbl [10];
    vec_t        idle;
    exp_t        sb [$];
    int          n_vec = 0;
    int          n_bad = 0;
    int unsigned cyc_n = 0;
    bit          lat_chk = 1'b0;
    int unsigned m0 [5];
    int unsigned m2 [5];

    logic        seen_rdy;
    logic        seen_ov;
    logic [31:0] seen_instr;
    logic [4:0]  seen_cls;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_models();
        for (int i = 0; i < 5; i++) begin
            m0[i] = 0;
            m2[i] = 0;
        end
    endtask

    // One clock cycle: drive at negedge, score transfers just before posedge.
    task automatic cyc(input vec_t t, input logic v, input logic ordy,
                       input logic fl, input logic clr);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        instr     = t.ins;
        out_ready = ordy;
        flush     = fl;
        cnt_clr   = clr;
        #1;
        seen_rdy   = rdy0;
        seen_ov    = ov0;
        seen_instr = io0;
        seen_cls   = cls0;
        if (ov0 && ordy) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_out: got %0h expected no output", io0);
            end else begin
                e = sb.pop_front();
                chk("instr", io0, e.ins);
                chk("class", {27'd0, cls0}, {27'd0, e.cls});
                chk("select", {31'd0, sel0}, {31'd0, e.sel});
                chk("mask_class", {27'd0, cls1}, {27'd0, e.cls});
                chk("mask_select", {31'd0, sel1}, {31'd0, |(e.cls & 5'b00011)});
                chk("c3_valid", {31'd0, ov2}, 32'd1);
                chk("c3_instr", io2, e.ins);
                if (lat_chk) begin
                    chk("latency", cyc_n - e.acc, STAGES);
                end
                for (int i = 0; i < 5; i++) begin
                    if (e.cls[i]) begin
                        m0[i]++;
                        if (m2[i] != 7) m2[i]++;
                    end
                end
            end
        end
        if (fl) begin
            sb.delete();
        end else if (v && rdy0) begin
            e.ins = t.ins;
            e.cls = t.cls;
            e.sel = t.sel;
            e.acc = cyc_n;
            sb.push_back(e);
        end
        if (clr) clear_models();
        @(posedge clk);
        cyc_n++;
    endtask

    // Compare every counter of every instance against the model.
    task automatic check_cnts();
        int unsigned e0;
        int unsigned e2;
        #1;
        for (int s = 0; s < 8; s++) begin
            cnt_sel = 3'(s);
            #1;
            e0 = 0;
            e2 = 0;
            if (s < 5) begin
                e0 = m0[s];
                e2 = m2[s];
            end
            chk($sformatf("cnt0[%0d]", s), {16'd0, cnt0}, e0);
            chk($sformatf("cnt1[%0d]", s), {16'd0, cnt1}, e0);
            chk($sformatf("cnt2[%0d]", s), {29'd0, cnt2}, e2);
        end
        cnt_sel = 3'd0;
    endtask

    // One reset cycle, optionally with live traffic, flush and clear asserted.
    task automatic do_reset(input logic busy);
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = busy;
        instr     = 32'h00031843;
        out_ready = 1'b1;
        flush     = busy;
        cnt_clr   = 1'b0;
        @(posedge clk);
        cyc_n++;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
        sb.delete();
        clear_models();
        chk("rst_out_valid", {31'd0, ov0}, 32'd0);
        chk("rst_in_ready", {31'd0, rdy0}, 32'd1);
        chk("rst_mask_valid", {31'd0, ov1}, 32'd0);
        chk("rst_c3_valid", {31'd0, ov2}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        instr     = '0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        cnt_sel   = 3'd0;
        cnt_clr   = 1'b0;
        clear_models();

        idle    = '{32'h0, 5'b00000, 1'b0};
        tbl[0]  = '{32'h00031843, 5'b00001, 1'b1};  // SRA
        tbl[1]  = '{32'h3C011234, 5'b00100, 1'b1};  // LUI
        tbl[2]  = '{32'h34210001, 5'b01000, 1'b1};  // ORI
        tbl[3]  = '{32'h1420FFFF, 5'b10000, 1'b1};  // BNE
        tbl[4]  = '{32'h00000020, 5'b00000, 1'b0};  // ADD
        tbl[5]  = '{32'h00221007, 5'b00010, 1'b1};  // SRAV
        tbl[6]  = '{32'h08000003, 5'b00000, 1'b0};  // J, funct bits look like SRA
        tbl[7]  = '{32'h3C000007, 5'b00100, 1'b1};  // LUI, funct bits look like SRAV
        tbl[8]  = '{32'h0010F8C3, 5'b00001, 1'b1};  // SRA with other fields set
        tbl[9]  = '{32'h00031842, 5'b00000, 1'b0};  // SRL

        repeat (2) @(posedge clk);
        do_reset(1'b0);
        chk("rst_instr", io0, 32'd0);
        chk("rst_class", {27'd0, cls0}, 32'd0);
        chk("rst_select", {31'd0, sel0}, 32'd0);
        check_cnts();

        // Unstalled stream through the whole table with latency checks.
        lat_chk = 1'b1;
        for (int i = 0; i < 10; i++) cyc(tbl[i], 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) cyc(idle, 1'b0, 1'b1, 1'b0, 1'b0);
        lat_chk = 1'b0;
        chk("stream_drained", sb.size(), 32'd0);
        check_cnts();

        // Fill with output stalled: two accepts then backpressure, output frozen.
        for (int k = 0; k < 5; k++) begin
            cyc(tbl[5 + k], 1'b1, 1'b0, 1'b0, 1'b0);
            chk($sformatf("fill_ready%0d", k), {31'd0, seen_rdy}, (k < 2) ? 32'd1 : 32'd0);
            if (k >= 2) begin
                chk("stall_valid", {31'd0, seen_ov}, 32'd1);
                chk("stall_instr", seen_instr, tbl[5].ins);
                chk("stall_class", {27'd0, seen_cls}, {27'd0, tbl[5].cls});
            end
        end
        for (int k = 0; k < 4; k++) begin
            cyc(idle, 1'b0, 1'b1, 1'b0, 1'b0);
            chk($sformatf("release_valid%0d", k), {31'd0, seen_ov}, (k < 2) ? 32'd1 : 32'd0);
        end
        chk("release_drained", sb.size(), 32'd0);

        // Flush with two in flight, one being accepted, and an output transfer.
        cyc(tbl[0], 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(tbl[1], 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(tbl[2], 1'b1, 1'b1, 1'b1, 1'b0);
        chk("flush_xfer_valid", {31'd0, seen_ov}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            cyc(idle, 1'b0, 1'b1, 1'b0, 1'b0);
            chk($sformatf("post_flush_valid%0d", k), {31'd0, seen_ov}, 32'd0);
        end
        check_cnts();

        // Flush while stalled: the held output is dropped uncounted.
        cyc(tbl[3], 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(idle, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(idle, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("stalled_flush_valid", {31'd0, seen_ov}, 32'd1);
        cyc(idle, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("stalled_post_flush", {31'd0, seen_ov}, 32'd0);
        check_cnts();

        // Saturation of the 3-bit counter.
        for (int k = 0; k < 9; k++) cyc(tbl[0], 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (2) cyc(idle, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        cnt_sel = 3'd0;
        #1;
        chk("c3_saturated", {29'd0, cnt2}, 32'd7);
        check_cnts();

        // Clear coinciding with an SRA output transfer.
        cyc(tbl[0], 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(idle, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(idle, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("clr_xfer_valid", {31'd0, seen_ov}, 32'd1);
        #1;
        cnt_sel = 3'd0;
        #1;
        chk("c3_cleared", {29'd0, cnt2}, 32'd0);
        chk("c16_cleared", {16'd0, cnt0}, 32'd0);
        check_cnts();

        // Reset in the middle of a stream with counters non-zero.
        cyc(tbl[1], 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(tbl[3], 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(tbl[2], 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(tbl[5], 1'b1, 1'b1, 1'b0, 1'b0);
        do_reset(1'b1);
        check_cnts();
        repeat (3) cyc(idle, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("post_reset_quiet", {31'd0, seen_ov}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
